// File: rtl/decoder_scan_if.sv
// -----------------------------------------------------------------------------
// decoder_scan_if
//   Bundles the control and result signals of decoder_scan.
//
//   master : the controller. It drives en/mode/load/sel_in/dir and observes
//            out/idx/wrap.
//   slave  : the decoder itself.
//
//   Signals
//     en     - block enable
//     mode   - 0 = direct decode, 1 = automatic scan
//     load   - load sel_in into the index register
//     sel_in - select value to load (SEL_W bits)
//     dir    - scan direction, 0 = up, 1 = down
//     out    - registered one-hot / one-cold decode (2^SEL_W bits)
//     idx    - registered current index
//     wrap   - one-cycle pulse when a scan step wraps around
// -----------------------------------------------------------------------------
interface decoder_scan_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel_in;
    logic             dir;
    logic [N-1:0]     out;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, load, sel_in, dir,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, load, sel_in, dir,
        output out, idx, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//   Parametrised 1-of-2^SEL_W decoder with registered outputs. In direct mode
//   it decodes a loaded select value; in scan mode the active output steps
//   every DIV enabled cycles, up or down, wrapping at the ends. Typical use is
//   digit/row strobing or round-robin channel enables.
//
//   Parameters
//     SEL_W      - select width (1..6); 2^SEL_W outputs
//     DIV        - clock cycles per scan step (>= 1)
//     ACTIVE_LOW - 1 inverts every out bit (one-cold)
//
//   Ports
//     clk - rising-edge clock
//     rst - synchronous, active-high reset (highest priority)
//     bus - decoder_scan_if slave port: en, mode, load, sel_in, dir in;
//           out, idx, wrap out (all outputs are flops)
// -----------------------------------------------------------------------------
module decoder_scan #(
    parameter int SEL_W      = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    decoder_scan_if.slave bus
);
    localparam int N  = 1 << SEL_W;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [SEL_W-1:0] IDX_MAX  = SEL_W'(N - 1);
    localparam logic [PW-1:0]    PRES_TOP = PW'(DIV - 1);
    // XOR mask applied to the decode; all-ones turns one-hot into one-cold.
    localparam logic [N-1:0]     POL      = ACTIVE_LOW ? '1 : '0;

    logic [SEL_W-1:0] idx_q,   idx_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             wrap_q,  wrap_d;
    logic [N-1:0]     out_q,   out_d;

    // Next-state logic.
    // NOTE: every variable gets a default at the top of always_comb so that no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        idx_d   = idx_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;

        if (bus.en) begin
            if (bus.load) begin
                // A load restarts the scan period and never reports a wrap.
                idx_d   = bus.sel_in;
                presc_d = '0;
            end else if (bus.mode) begin
                if (presc_q == PRES_TOP) begin
                    presc_d = '0;
                    if (bus.dir) begin
                        idx_d  = idx_q - 1'b1;
                        wrap_d = (idx_q == '0);
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        wrap_d = (idx_q == IDX_MAX);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end else begin
                // Direct mode keeps the prescaler parked, so entering scan
                // mode always starts a full period.
                presc_d = '0;
            end
        end

        // Decode the index that will be registered alongside out, so out and
        // idx always agree in the same cycle. The registered enable is folded
        // into out_q itself: a disabled cycle registers all-inactive.
        out_d = (bus.en ? (N'(1) << idx_d) : '0) ^ POL;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
            out_q   <= POL;
        end else begin
            idx_q   <= idx_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
            out_q   <= out_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan
//   Directed bench for decoder_scan. Instance A: SEL_W=3, DIV=4, active-high.
//   Instance B: SEL_W=2, DIV=1, active-low. Inputs change and outputs are
//   sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_decoder_scan;

    logic clk = 1'b0;
    logic rst_a, rst_b;

    always #5 clk = ~clk;

    decoder_scan_if #(.SEL_W(3)) bus_a ();
    decoder_scan_if #(.SEL_W(2)) bus_b ();

    decoder_scan #(.SEL_W(3), .DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    decoder_scan #(.SEL_W(2), .DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_a(input string tag, input logic [2:0] e_idx,
                           input logic [7:0] e_out, input logic e_wrap);
        check({tag, ".idx"},  64'(bus_a.idx),  64'(e_idx));
        check({tag, ".out"},  64'(bus_a.out),  64'(e_out));
        check({tag, ".wrap"}, 64'(bus_a.wrap), 64'(e_wrap));
    endtask

    task automatic check_b(input string tag, input logic [1:0] e_idx,
                           input logic [3:0] e_out, input logic e_wrap);
        check({tag, ".idx"},  64'(bus_b.idx),  64'(e_idx));
        check({tag, ".out"},  64'(bus_b.out),  64'(e_out));
        check({tag, ".wrap"}, 64'(bus_b.wrap), 64'(e_wrap));
    endtask

    // Apply one set of inputs to A across one rising edge; return at the
    // following falling edge, ready to sample.
    task automatic drive_a(input logic en, input logic mode, input logic load,
                           input logic [2:0] sel, input logic dir);
        bus_a.en     = en;
        bus_a.mode   = mode;
        bus_a.load   = load;
        bus_a.sel_in = sel;
        bus_a.dir    = dir;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_b(input logic en, input logic mode, input logic load,
                           input logic [1:0] sel, input logic dir);
        bus_b.en     = en;
        bus_b.mode   = mode;
        bus_b.load   = load;
        bus_b.sel_in = sel;
        bus_b.dir    = dir;
        @(posedge clk);
        @(negedge clk);
    endtask

    // rep cycles of identical inputs; the expectation is checked after each.
    typedef struct {
        int         rep;
        logic       en;
        logic       mode;
        logic       load;
        logic [2:0] sel;
        logic       dir;
        logic [2:0] e_idx;
        logic [7:0] e_out;
        logic       e_wrap;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Direct decode and hold.
        vecs[0]  = '{1, 1, 0, 1, 3'd5, 0, 3'd5, 8'h20, 0};
        vecs[1]  = '{3, 1, 0, 0, 3'd2, 0, 3'd5, 8'h20, 0};
        // Load 6, then scan up across the wrap 7 -> 0.
        vecs[2]  = '{1, 1, 0, 1, 3'd6, 0, 3'd6, 8'h40, 0};
        vecs[3]  = '{3, 1, 1, 0, 3'd0, 0, 3'd6, 8'h40, 0};
        vecs[4]  = '{1, 1, 1, 0, 3'd0, 0, 3'd7, 8'h80, 0};
        vecs[5]  = '{3, 1, 1, 0, 3'd0, 0, 3'd7, 8'h80, 0};
        vecs[6]  = '{1, 1, 1, 0, 3'd0, 0, 3'd0, 8'h01, 1};
        vecs[7]  = '{3, 1, 1, 0, 3'd0, 0, 3'd0, 8'h01, 0};
        vecs[8]  = '{1, 1, 1, 0, 3'd0, 0, 3'd1, 8'h02, 0};
        // Scan down across the wrap 0 -> 7.
        vecs[9]  = '{3, 1, 1, 0, 3'd0, 1, 3'd1, 8'h02, 0};
        vecs[10] = '{1, 1, 1, 0, 3'd0, 1, 3'd0, 8'h01, 0};
        vecs[11] = '{3, 1, 1, 0, 3'd0, 1, 3'd0, 8'h01, 0};
        vecs[12] = '{1, 1, 1, 0, 3'd0, 1, 3'd7, 8'h80, 1};
        vecs[13] = '{1, 1, 1, 0, 3'd0, 1, 3'd7, 8'h80, 0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_b.en = 1'b1; bus_b.mode = 1'b1; bus_b.load = 1'b1;
        bus_b.sel_in = 2'd2; bus_b.dir = 1'b0;

        // ---- Reset: two cycles, with A's inputs trying to load.
        @(negedge clk);
        drive_a(1, 0, 1, 3'd5, 0);
        check_a("rst_a0", 3'd0, 8'h00, 0);
        check_b("rst_b0", 2'd0, 4'hF, 0);
        drive_a(1, 1, 1, 3'd5, 0);
        check_a("rst_a1", 3'd0, 8'h00, 0);
        check_b("rst_b1", 2'd0, 4'hF, 0);
        rst_a = 1'b0;

        // ---- Direct decode, scan up, scan down.
        for (int v = 0; v < 14; v++) begin
            for (int r = 0; r < vecs[v].rep; r++) begin
                drive_a(vecs[v].en, vecs[v].mode, vecs[v].load,
                        vecs[v].sel, vecs[v].dir);
                check_a($sformatf("vec%0d.%0d", v, r),
                        vecs[v].e_idx, vecs[v].e_out, vecs[v].e_wrap);
            end
        end

        // ---- Load on the terminal prescaler count (idx=7, presc=1 now).
        drive_a(1, 1, 0, 3'd0, 0);
        check_a("pre_ld0", 3'd7, 8'h80, 0);
        drive_a(1, 1, 0, 3'd0, 0);
        check_a("pre_ld1", 3'd7, 8'h80, 0);
        // presc==3: an unloaded edge would step 7->0 and wrap.
        drive_a(1, 1, 1, 3'd3, 0);
        check_a("ld_top", 3'd3, 8'h08, 0);
        for (int i = 0; i < 3; i++) begin
            drive_a(1, 1, 0, 3'd0, 0);
            check_a($sformatf("post_ld%0d", i), 3'd3, 8'h08, 0);
        end
        drive_a(1, 1, 0, 3'd0, 0);
        check_a("post_ld_step", 3'd4, 8'h10, 0);

        // ---- Enable gating: scan down to idx=2 with presc=1.
        for (int i = 0; i < 9; i++) drive_a(1, 1, 0, 3'd0, 1);
        check_a("gap_pre", 3'd2, 8'h04, 0);
        for (int i = 0; i < 6; i++) begin
            drive_a(0, 1, i[0], 3'd7, 0);
            check_a($sformatf("gap%0d", i), 3'd2, 8'h00, 0);
        end
        drive_a(1, 1, 0, 3'd0, 0);
        check_a("reen0", 3'd2, 8'h04, 0);
        drive_a(1, 1, 0, 3'd0, 0);
        check_a("reen1", 3'd2, 8'h04, 0);
        drive_a(1, 1, 0, 3'd0, 0);
        check_a("reen_step", 3'd3, 8'h08, 0);

        // ---- Reset beats an active load.
        rst_a = 1'b1;
        drive_a(1, 0, 1, 3'd6, 0);
        check_a("rst_prio", 3'd0, 8'h00, 0);
        rst_a = 1'b0;

        // ---- Instance B: active-low, DIV=1, scan up, step every cycle.
        drive_b(1, 1, 1, 2'd2, 0);
        check_b("b_rst_hold", 2'd0, 4'hF, 0);
        rst_b = 1'b0;
        drive_b(1, 1, 1, 2'd0, 0);
        check_b("b_ld", 2'd0, 4'b1110, 0);
        drive_b(1, 1, 0, 2'd0, 0);
        check_b("b_s1", 2'd1, 4'b1101, 0);
        drive_b(1, 1, 0, 2'd0, 0);
        check_b("b_s2", 2'd2, 4'b1011, 0);
        drive_b(1, 1, 0, 2'd0, 0);
        check_b("b_s3", 2'd3, 4'b0111, 0);
        drive_b(1, 1, 0, 2'd0, 0);
        check_b("b_wrap", 2'd0, 4'b1110, 1);
        drive_b(1, 1, 0, 2'd0, 0);
        check_b("b_s5", 2'd1, 4'b1101, 0);
        drive_b(0, 1, 0, 2'd0, 0);
        check_b("b_dis", 2'd1, 4'b1111, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
